// File: rtl/lms_adaptive_fir_pkg.sv
// Shared types and helpers for the LMS adaptive FIR and its MAC unit.
package lms_adaptive_fir_pkg;

    // Sequencer states: one pass through FILTER, ERROR, optional UPDATE, DONE per sample.
    typedef enum logic [2:0] {
        StIdle,
        StFilter,
        StError,
        StUpdate,
        StDone
    } state_t;

    // Ceiling log2, minimum 1 so a tap index always has at least one bit.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

    // Right shift taking e*x (two Q1.(D-1) samples) down to a weight step of mu*e*x.
    function automatic int unsigned update_shift(input int unsigned data_size,
                                                 input int unsigned coef_frac,
                                                 input int unsigned mu_shift);
        return 2 * (data_size - 1) - coef_frac + mu_shift;
    endfunction

    // Multiplier b operand carries weights in FILTER and the error in UPDATE.
    function automatic int unsigned mul_b_width(input int unsigned data_size,
                                                input int unsigned coef_size);
        return (data_size > coef_size) ? data_size : coef_size;
    endfunction

    // Clamp a signed value to the signed range of a 'width'-bit word; caller slices.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                      input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (val > hi) return hi;
        if (val < lo) return lo;
        return val;
    endfunction

    // Trigger cycle to filter_done cycle. The multiplier is not pipelined, so no extra cycles.
    function automatic int unsigned latency_no_adapt(input int unsigned taps);
        return taps + 3;
    endfunction

    function automatic int unsigned latency_adapt(input int unsigned taps);
        return 2 * taps + 3;
    endfunction

endpackage

// File: rtl/lms_adaptive_fir_mac.sv
// Shared signed multiplier with a clearable accumulator; product is also exposed directly.
module lms_mac_unit
    import lms_adaptive_fir_pkg::*;
#(
    parameter int unsigned A_W   = 24,
    parameter int unsigned B_W   = 24,
    parameter int unsigned ACC_W = 47
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [A_W-1:0]     a,
    input  logic signed [B_W-1:0]     b,
    input  logic                      clear,
    input  logic                      acc_en,
    output logic signed [A_W+B_W-1:0] product,
    output logic signed [ACC_W-1:0]   acc
);

    localparam int unsigned P_W   = A_W + B_W;
    localparam int unsigned EXT_W = (ACC_W > P_W) ? ACC_W : P_W;

    logic signed [EXT_W-1:0] acc_sum;

    // Product and the sign-extended running sum; the sum never exceeds ACC_W bits.
    always_comb begin
        product = a * b;
        acc_sum = EXT_W'(acc) + EXT_W'(product);
    end

    // Accumulator register, cleared at the start of each sample.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc_sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/lms_adaptive_fir.sv
// Serial-MAC LMS adaptive FIR: filter, error, optional weight update, one multiplier.
module lms_adaptive_fir
    import lms_adaptive_fir_pkg::*;
#(
    parameter int unsigned COEF_SIZE = 20,
    parameter int unsigned COEF_FRAC = 18,
    parameter int unsigned DATA_SIZE = 24,
    parameter int unsigned TAPS      = 8,
    parameter int unsigned MU_SHIFT  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [DATA_SIZE-1:0] data_in,
    input  logic signed [DATA_SIZE-1:0] desired_in,
    input  logic                        sample_trig,
    input  logic                        adapt_en,
    output logic signed [DATA_SIZE-1:0] data_out,
    output logic signed [DATA_SIZE-1:0] error_out,
    output logic                        filter_done,
    output logic                        busy,
    output logic                        overrun
);

    localparam int unsigned TAP_W = clog2_f(TAPS);
    localparam int unsigned ACC_W = DATA_SIZE + COEF_SIZE + clog2_f(TAPS);
    localparam int unsigned B_W   = mul_b_width(DATA_SIZE, COEF_SIZE);
    localparam int unsigned P_W   = DATA_SIZE + B_W;
    localparam int unsigned SHIFT = update_shift(DATA_SIZE, COEF_FRAC, MU_SHIFT);

    state_t                      state_q;
    logic [TAP_W-1:0]            tap_q;
    logic signed [DATA_SIZE-1:0] x_q [TAPS];
    logic signed [COEF_SIZE-1:0] w_q [TAPS];
    logic signed [DATA_SIZE-1:0] d_q;
    logic                        adapt_q;
    logic signed [DATA_SIZE-1:0] y_q;
    logic signed [DATA_SIZE-1:0] e_q;

    logic                        accept;
    logic                        last_tap;
    logic signed [B_W-1:0]       mac_b;
    logic signed [P_W-1:0]       product;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     y_full;
    logic signed [63:0]          y_sat64;
    logic signed [DATA_SIZE-1:0] y_sat;
    logic signed [DATA_SIZE:0]   e_full;
    logic signed [63:0]          e_sat64;
    logic signed [DATA_SIZE-1:0] e_sat;
    logic signed [P_W-1:0]       delta;
    logic signed [63:0]          w_new64;
    logic signed [COEF_SIZE-1:0] w_new;

    // Operand select, output scaling/saturation and the saturated weight step.
    always_comb begin
        // The filter_done cycle is still busy, so a trigger there is refused.
        accept   = (state_q == StIdle) && sample_trig && !busy;
        last_tap = (tap_q == TAP_W'(TAPS - 1));
        if (state_q == StUpdate) begin
            mac_b = B_W'(e_q);
        end else begin
            mac_b = B_W'(w_q[tap_q]);
        end
        y_full  = acc >>> COEF_FRAC;
        y_sat64 = sat_signed(64'(y_full), DATA_SIZE);
        y_sat   = y_sat64[DATA_SIZE-1:0];
        e_full  = {d_q[DATA_SIZE-1], d_q} - {y_sat[DATA_SIZE-1], y_sat};
        e_sat64 = sat_signed(64'(e_full), DATA_SIZE);
        e_sat   = e_sat64[DATA_SIZE-1:0];
        delta   = product >>> SHIFT;
        w_new64 = sat_signed(64'(w_q[tap_q]) + 64'(delta), COEF_SIZE);
        w_new   = w_new64[COEF_SIZE-1:0];
    end

    lms_mac_unit #(
        .A_W   (DATA_SIZE),
        .B_W   (B_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .a       (x_q[tap_q]),
        .b       (mac_b),
        .clear   (accept),
        .acc_en  (state_q == StFilter),
        .product (product),
        .acc     (acc)
    );

    // Sequencer with delay line, weights and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            tap_q       <= '0;
            d_q         <= '0;
            adapt_q     <= 1'b0;
            y_q         <= '0;
            e_q         <= '0;
            data_out    <= '0;
            error_out   <= '0;
            filter_done <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < int'(TAPS); i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            filter_done <= 1'b0;
            if (sample_trig && busy) overrun <= 1'b1;
            if (filter_done) busy <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        for (int i = int'(TAPS) - 1; i > 0; i--) begin
                            x_q[i] <= x_q[i-1];
                        end
                        x_q[0]  <= data_in;
                        d_q     <= desired_in;
                        adapt_q <= adapt_en;
                        tap_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StFilter;
                    end
                end
                StFilter: begin
                    tap_q <= last_tap ? '0 : tap_q + TAP_W'(1);
                    if (last_tap) state_q <= StError;
                end
                StError: begin
                    y_q     <= y_sat;
                    e_q     <= e_sat;
                    state_q <= adapt_q ? StUpdate : StDone;
                end
                StUpdate: begin
                    w_q[tap_q] <= w_new;
                    tap_q      <= last_tap ? '0 : tap_q + TAP_W'(1);
                    if (last_tap) state_q <= StDone;
                end
                StDone: begin
                    data_out    <= y_q;
                    error_out   <= e_q;
                    filter_done <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_adaptive_fir.sv
// Directed bench for lms_adaptive_fir with TAPS=4, MU_SHIFT=2.
module tb_lms_adaptive_fir;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [23:0] data_in = '0;
    logic signed [23:0] desired_in = '0;
    logic               sample_trig = 1'b0;
    logic               adapt_en = 1'b0;
    logic signed [23:0] data_out;
    logic signed [23:0] error_out;
    logic               filter_done;
    logic               busy;
    logic               overrun;

    int errors = 0;
    int checks = 0;

    lms_adaptive_fir #(
        .COEF_SIZE (20),
        .COEF_FRAC (18),
        .DATA_SIZE (24),
        .TAPS      (4),
        .MU_SHIFT  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .desired_in  (desired_in),
        .sample_trig (sample_trig),
        .adapt_en    (adapt_en),
        .data_out    (data_out),
        .error_out   (error_out),
        .filter_done (filter_done),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One sample; lat returns the cycle (trigger cycle = 0) where filter_done is seen.
    // pulse_at != 0 drives an extra trigger in that cycle.
    task automatic run_sample(input logic signed [23:0] x, input logic signed [23:0] d,
                              input logic ad, input int pulse_at, output int lat);
        @(posedge clk); #1;
        data_in = x;
        desired_in = d;
        adapt_en = ad;
        sample_trig = 1'b1;
        @(posedge clk); #1;
        sample_trig = 1'b0;
        lat = 1;
        while (filter_done !== 1'b1 && lat < 60) begin
            sample_trig = (lat == pulse_at);
            @(posedge clk); #1;
            lat++;
            sample_trig = 1'b0;
        end
    endtask

    initial begin
        int lat;
        int wsum;
        int prev_e;
        int mono;
        int reached;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", 64'(data_out), 0);
        check("rst_error_out", 64'(error_out), 0);
        check("rst_done", filter_done, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_w0", 64'(dut.w_q[0]), 0);
        reset = 1'b0;

        // First sample: y=0, e=0x400000, w0 += 2^44 >> 30
        run_sample(24'sh400000, 24'sh400000, 1'b1, 0, lat);
        check("s1_latency", lat, 11);
        check("s1_data_out", 64'(data_out), 0);
        check("s1_error_out", 64'(error_out), 64'sh400000);
        check("s1_busy_in_done", busy, 1);
        check("s1_w0", 64'(dut.w_q[0]), 16384);
        check("s1_w1", 64'(dut.w_q[1]), 0);
        check("s1_w3", 64'(dut.w_q[3]), 0);
        check("s1_overrun", overrun, 0);

        // Second identical sample: y=2^18, e=0x3C0000, step = e/256 = 15360
        run_sample(24'sh400000, 24'sh400000, 1'b1, 0, lat);
        check("s2_latency", lat, 11);
        check("s2_data_out", 64'(data_out), 64'sh040000);
        check("s2_error_out", 64'(error_out), 64'sh3C0000);
        check("s2_w0", 64'(dut.w_q[0]), 31744);
        check("s2_w1", 64'(dut.w_q[1]), 15360);

        // No adaptation: y = (31744+15360)*16 = 0xB8000, e = 0x348000
        run_sample(24'sh400000, 24'sh400000, 1'b0, 0, lat);
        check("s3_latency", lat, 7);
        check("s3_data_out", 64'(data_out), 64'sh0B8000);
        check("s3_error_out", 64'(error_out), 64'sh348000);
        check("s3_w0", 64'(dut.w_q[0]), 31744);
        check("s3_w1", 64'(dut.w_q[1]), 15360);
        check("s3_w2", 64'(dut.w_q[2]), 0);
        @(posedge clk); #1;
        check("s3_busy_after", busy, 0);
        check("s3_done_after", filter_done, 0);
        check("s3_hold_data_out", 64'(data_out), 64'sh0B8000);

        // Training: error shrinks by about 3/4 per sample and settles below 256
        prev_e = 32'h348000;
        mono = 1;
        for (int n = 0; n < 40; n++) begin
            run_sample(24'sh400000, 24'sh400000, 1'b1, 0, lat);
            if (int'(error_out) > prev_e || int'(error_out) < 0) mono = 0;
            prev_e = int'(error_out);
        end
        check("train_monotonic", mono, 1);
        check("train_small_err", (int'(error_out) < 32'h1000) && (int'(error_out) >= 0), 1);
        wsum = int'(dut.w_q[0]) + int'(dut.w_q[1]) + int'(dut.w_q[2]) + int'(dut.w_q[3]);
        check("train_wsum", (wsum >= 261888) && (wsum <= 262144), 1);

        // Overrun: second trigger 3 cycles in is dropped, first sample unaffected
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        run_sample(24'sh400000, 24'sh400000, 1'b1, 3, lat);
        check("ovr_latency", lat, 11);
        check("ovr_flag", overrun, 1);
        check("ovr_data_out", 64'(data_out), 0);
        check("ovr_error_out", 64'(error_out), 64'sh400000);
        check("ovr_w0", 64'(dut.w_q[0]), 16384);
        repeat (3) @(posedge clk);
        #1;
        check("ovr_sticky", overrun, 1);

        // Reset in the middle of UPDATE (cycle 7 of an adapting sample)
        data_in = 24'sh400000;
        desired_in = 24'sh400000;
        adapt_en = 1'b1;
        sample_trig = 1'b1;
        @(posedge clk); #1;
        sample_trig = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_data_out", 64'(data_out), 0);
        check("mid_error_out", 64'(error_out), 0);
        check("mid_busy", busy, 0);
        check("mid_overrun", overrun, 0);
        check("mid_done", filter_done, 0);
        check("mid_w0", 64'(dut.w_q[0]), 0);
        check("mid_w1", 64'(dut.w_q[1]), 0);
        run_sample(24'sh400000, 24'sh400000, 1'b1, 0, lat);
        check("mid_s1_latency", lat, 11);
        check("mid_s1_data_out", 64'(data_out), 0);
        check("mid_s1_error_out", 64'(error_out), 64'sh400000);
        check("mid_s1_w0", 64'(dut.w_q[0]), 16384);

        // Negative training, then full-scale x and d: e must clamp at 0x7FFFFF
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        reached = 0;
        for (int n = 0; n < 30 && reached == 0; n++) begin
            run_sample(24'sh400000, 24'shC00000, 1'b1, 0, lat);
            if (int'(data_out) <= -32'sd1048576) reached = 1;
        end
        check("neg_train_reached", reached, 1);
        run_sample(24'sh7FFFFF, 24'sh7FFFFF, 1'b0, 0, lat);
        check("sat_latency", lat, 7);
        check("sat_error_out", 64'(error_out), 64'sh7FFFFF);
        check("sat_y_negative", data_out[23], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lms_adaptive_fir.md
Name: lms_adaptive_fir

Overview:
- Serial-MAC LMS adaptive FIR that sits directly downstream of the band-pass SOS cascade.
- Consumes its `data_out` / `filter_end` pair as input sample `x` and sample strobe.
- Per sample, it filters `x` through TAPS adaptive weights, forms the error against a desired reference `d`, and updates the weights, all with one shared multiplier.
- Emits `y`, `e` and a one-cycle done strobe, so further stages can chain on it.

Parameters:
- COEF_SIZE, 20: weight width, signed, COEF_FRAC fractional bits (1.0 = 262144).
- COEF_FRAC, 18: fractional bits of weights.
- DATA_SIZE, 24: sample width, signed Q1.(DATA_SIZE-1).
- TAPS, 8: number of adaptive taps (≥2).
- MU_SHIFT, 4: step size mu = 2^-MU_SHIFT.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- data_in  in  DATA_SIZE  sample x (from band-pass output).
- desired_in  in  DATA_SIZE  reference d, sampled with data_in.
- sample_trig  in  1  one-cycle strobe; data_in/desired_in valid this cycle.
- adapt_en  in  1  1 = perform weight update for this sample; sampled with sample_trig.
- data_out  out  DATA_SIZE  filter output y.
- error_out  out  DATA_SIZE  error e = d - y.
- filter_done  out  1  one-cycle strobe; data_out/error_out updated this cycle.
- busy  out  1  high from the cycle after an accepted trigger through the filter_done cycle.
- overrun  out  1  sticky; set when sample_trig arrives while busy.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - All outputs 0.
  - Delay line x[0..TAPS-1] = 0.
  - Weights w[0..TAPS-1] = 0.
  - FSM returns to IDLE.
  - Any in-progress sample is discarded.
- FSM states: IDLE, FILTER, ERROR, UPDATE, DONE.
- IDLE, sample_trig=1:
  - Shift delay line (x[k] <= x[k-1], x[0] <= data_in).
  - Latch d and adapt_en.
  - Clear accumulator; go to FILTER.
- FILTER: TAPS cycles, tap index k = 0..TAPS-1.
  - acc += x[k]*w[k].
  - Accumulator width DATA_SIZE+COEF_SIZE+clog2(TAPS), no overflow possible.
- ERROR: 1 cycle.
  - y = acc >>> COEF_FRAC (floor), saturated to the DATA_SIZE signed range.
  - e = d - y, computed at DATA_SIZE+1 bits and saturated to DATA_SIZE.
  - Register both to data_out/error_out shadow.
  - Go to UPDATE if latched adapt_en=1, else DONE.
- UPDATE: TAPS cycles, k = 0..TAPS-1.
  - delta = (e*x[k]) >>> (2*(DATA_SIZE-1) - COEF_FRAC + MU_SHIFT), floor.
  - w[k] <= sat_COEF(w[k] + delta).
  - x[k] is the post-shift delay line (current sample at k=0).
- DONE: 1 cycle.
  - data_out/error_out take the new values.
  - filter_done=1; return to IDLE.
- Latency, trigger cycle to filter_done:
  - TAPS+3 cycles without adaptation.
  - 2*TAPS+3 cycles with adaptation.
  - data_out/error_out hold between samples.
- Trigger while busy (any non-IDLE state, including DONE):
  - Sample ignored; overrun <= 1.
  - Cleared only by reset.
- Trigger in the same cycle as filter_done: treated as busy, i.e. ignored and overrun set.
- Upstream strobe rate: the SOS cascade strobe rate must exceed 2*TAPS+3 clk cycles; overrun flags violations.
- Weights saturate at +/-(2^(COEF_SIZE-1)) bounds and never wrap.
- adapt_en changes outside the trigger cycle have no effect on the current sample.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - Function for update shift amount.
  - Saturation function (generic width).
  - clog2 helper.
- Sub-module lms_mac_unit: registered signed DATA_SIZE x COEF_SIZE multiplier plus accumulate/clear control, time-shared between FILTER (acc mode) and UPDATE (product-only mode).
- The pipeline register, if used, adds 1 cycle to each phase; the latency figures above then become TAPS+4 / 2*TAPS+5 and must be documented in the package constant.

Test Plan:
- Reset then single trigger, TAPS=4, MU_SHIFT=2, data_in=desired_in=0x400000, adapt_en=1 -> filter_done at cycle 11; data_out=0, error_out=0x400000, w0=16384, w1..w3=0.
- Second identical trigger -> data_out=0x040000 (262144), error_out=0x3C0000 (3932160); continue 200 samples -> error_out magnitude monotonically decreasing below 0x001000, sum of weights ≈ 262144.
- adapt_en=0 trigger after training -> filter_done at cycle TAPS+3=7, weights unchanged, error_out consistent with stored weights.
- Second sample_trig 3 cycles after the first -> ignored, overrun=1 and stays 1, first sample completes with unchanged result.
- Train with x=0x400000, d=0xC00000 until data_out ≤ 0xF00000, then x=0x7FFFFF, d=0x7FFFFF -> error_out=0x7FFFFF (saturated, no wrap).
- reset asserted mid-UPDATE -> next cycle all outputs 0, busy=0, weights 0; next trigger behaves as the first scenario.
